// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit pipelined processor.
// Also holds the write-back source select encoding used by the WB stage.
package cpu_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 2;
   localparam int REG_COUNT = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_MEM = 1'b1
   } wb_src_e;

endpackage

// File: rtl/regfile_4x8.sv
// Architectural register file: one write port, two combinational read ports.
// Reads bypass the write that is pending on the write port this cycle.
module regfile_4x8
   import cpu_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 2,
   parameter int                REG_COUNT = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [DATA_W-1:0] rs1_val,
   output logic [DATA_W-1:0] rs2_val
);

   logic [DATA_W-1:0] regs [REG_COUNT];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= RESET_VAL;
         end
      end else if (wr_en) begin
         regs[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      rs1_val = regs[rs1];
      rs2_val = regs[rs2];
      if (wr_en && (wr_idx == rs1)) begin
         rs1_val = wr_data;
      end
      if (wr_en && (wr_idx == rs2)) begin
         rs2_val = wr_data;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, source mux, commit counter,
// forwarding outputs, and the register file it commits into.
module wb_stage
   import cpu_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 2,
   parameter int                REG_COUNT = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Wr_MEM,
   input  logic              Rm_MEM,
   input  logic [ADDR_W-1:0] rdmem,
   input  logic [DATA_W-1:0] acOutWb,
   input  logic [DATA_W-1:0] data_out,
   input  logic              flush,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [DATA_W-1:0] rs1_val,
   output logic [DATA_W-1:0] rs2_val,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_val,
   output logic [7:0]        wb_count
);

   wb_src_e           wb_src;
   logic [DATA_W-1:0] wb_val_p0;

   logic              wb_wr_p1;
   logic [ADDR_W-1:0] wb_rd_p1;
   logic [DATA_W-1:0] wb_val_p1;

   // Stage 0: resolve the write-back source before capture
   always_comb begin
      wb_src    = Rm_MEM ? WB_SRC_MEM : WB_SRC_ALU;
      wb_val_p0 = acOutWb;
      case (wb_src)
         WB_SRC_MEM: wb_val_p0 = data_out;
         default:    wb_val_p0 = acOutWb;
      endcase
   end

   // Stage 1: MEM/WB pipeline register; a flushed slot keeps rd/val but is invalid
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_wr_p1  <= 1'b0;
         wb_rd_p1  <= '0;
         wb_val_p1 <= RESET_VAL;
      end else begin
         wb_wr_p1  <= Wr_MEM & ~flush;
         wb_rd_p1  <= rdmem;
         wb_val_p1 <= wb_val_p0;
      end
   end

   // Stage 2: commit; reset drops whatever is pending in stage 1
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_count <= 8'h00;
      end else if (wb_wr_p1) begin
         wb_count <= wb_count + 8'd1;
      end
   end

   regfile_4x8 #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .REG_COUNT (REG_COUNT),
      .RESET_VAL (RESET_VAL)
   ) u_regfile (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wb_wr_p1),
      .wr_idx  (wb_rd_p1),
      .wr_data (wb_val_p1),
      .rs1     (rs1),
      .rs2     (rs2),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val)
   );

   assign fwd_valid = wb_wr_p1;
   assign fwd_rd    = wb_rd_p1;
   assign fwd_val   = wb_val_p1;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: capture, bypass, commit, flush, counter wrap
// and reset dropping a pending write.
module tb_wb_stage;

   logic       clock = 1'b0;
   logic       reset;
   logic       Wr_MEM;
   logic       Rm_MEM;
   logic [1:0] rdmem;
   logic [7:0] acOutWb;
   logic [7:0] data_out;
   logic       flush;
   logic [1:0] rs1;
   logic [1:0] rs2;
   logic [7:0] rs1_val;
   logic [7:0] rs2_val;
   logic       fwd_valid;
   logic [1:0] fwd_rd;
   logic [7:0] fwd_val;
   logic [7:0] wb_count;

   int tests_run = 0;
   int tests_failed = 0;

   wb_stage dut (
      .clock     (clock),
      .reset     (reset),
      .Wr_MEM    (Wr_MEM),
      .Rm_MEM    (Rm_MEM),
      .rdmem     (rdmem),
      .acOutWb   (acOutWb),
      .data_out  (data_out),
      .flush     (flush),
      .rs1       (rs1),
      .rs2       (rs2),
      .rs1_val   (rs1_val),
      .rs2_val   (rs2_val),
      .fwd_valid (fwd_valid),
      .fwd_rd    (fwd_rd),
      .fwd_val   (fwd_val),
      .wb_count  (wb_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      Wr_MEM   = 1'b0;
      Rm_MEM   = 1'b0;
      flush    = 1'b0;
      rdmem    = 2'd0;
      acOutWb  = 8'h00;
      data_out = 8'h00;
   endtask

   task automatic drive(input logic wr, input logic rm, input logic fl,
                        input logic [1:0] rd, input logic [7:0] alu, input logic [7:0] mem);
      Wr_MEM   = wr;
      Rm_MEM   = rm;
      flush    = fl;
      rdmem    = rd;
      acOutWb  = alu;
      data_out = mem;
   endtask

   task automatic rd_both(input logic [1:0] idx);
      rs1 = idx;
      rs2 = idx;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      rs1 = 2'd0;
      rs2 = 2'd0;
      idle();
      step();
      step();
      reset = 1'b0;

      // reset state
      for (int i = 0; i < 4; i++) begin
         rd_both(2'(i));
         chk($sformatf("rst_rs1_%0d", i), 32'(rs1_val), 32'h00);
         chk($sformatf("rst_rs2_%0d", i), 32'(rs2_val), 32'h00);
      end
      chk("rst_count", 32'(wb_count), 32'h0);
      chk("rst_fwd_valid", 32'(fwd_valid), 32'h0);

      // ALU source: visible via bypass after N, architecturally after N+1
      drive(1'b1, 1'b0, 1'b0, 2'd2, 8'h5A, 8'hEE);
      step();
      idle();
      rd_both(2'd2);
      chk("alu_fwd_valid", 32'(fwd_valid), 32'h1);
      chk("alu_fwd_rd", 32'(fwd_rd), 32'h2);
      chk("alu_fwd_val", 32'(fwd_val), 32'h5A);
      chk("alu_bypass_rs1", 32'(rs1_val), 32'h5A);
      chk("alu_count_pre", 32'(wb_count), 32'h0);
      step();
      chk("alu_reg2", 32'(rs1_val), 32'h5A);
      chk("alu_count", 32'(wb_count), 32'h1);
      chk("alu_fwd_valid_clr", 32'(fwd_valid), 32'h0);

      // memory source selected
      drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h11, 8'hC3);
      step();
      idle();
      chk("mem_fwd_val", 32'(fwd_val), 32'hC3);
      step();
      rd_both(2'd1);
      chk("mem_reg1", 32'(rs1_val), 32'hC3);
      chk("mem_count", 32'(wb_count), 32'h2);

      // back-to-back writes to r3, both ports on the same index
      rd_both(2'd3);
      drive(1'b1, 1'b0, 1'b0, 2'd3, 8'h01, 8'h00);
      step();
      chk("b2b_first_rs1", 32'(rs1_val), 32'h01);
      chk("b2b_first_rs2", 32'(rs2_val), 32'h01);
      drive(1'b1, 1'b0, 1'b0, 2'd3, 8'h02, 8'h00);
      step();
      idle();
      #1;
      chk("b2b_second_rs1", 32'(rs1_val), 32'h02);
      chk("b2b_second_rs2", 32'(rs2_val), 32'h02);
      step();
      chk("b2b_final_r3", 32'(rs1_val), 32'h02);
      chk("b2b_count", 32'(wb_count), 32'h4);

      // flush squashes the write but rd/val are still captured
      drive(1'b1, 1'b0, 1'b1, 2'd0, 8'hFF, 8'h00);
      step();
      idle();
      rd_both(2'd0);
      chk("flush_fwd_valid", 32'(fwd_valid), 32'h0);
      chk("flush_fwd_val", 32'(fwd_val), 32'hFF);
      chk("flush_no_bypass", 32'(rs1_val), 32'h00);
      step();
      chk("flush_reg0", 32'(rs1_val), 32'h00);
      chk("flush_count", 32'(wb_count), 32'h4);

      // Wr_MEM=0 with Rm_MEM=1 leaves the file alone
      drive(1'b0, 1'b1, 1'b0, 2'd2, 8'h33, 8'h77);
      step();
      idle();
      step();
      rd_both(2'd2);
      chk("nowr_reg2", 32'(rs1_val), 32'h5A);
      chk("nowr_count", 32'(wb_count), 32'h4);

      // count 4 -> 0xFF with 251 writes, then one more wraps to 0
      for (int i = 0; i < 251; i++) begin
         drive(1'b1, 1'b0, 1'b0, 2'd0, 8'(i), 8'h00);
         step();
      end
      idle();
      step();
      chk("wrap_count_ff", 32'(wb_count), 32'hFF);
      rd_both(2'd0);
      chk("wrap_reg0_last", 32'(rs1_val), 32'hFA);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'hAB, 8'h00);
      step();
      idle();
      step();
      chk("wrap_count_00", 32'(wb_count), 32'h00);
      chk("wrap_reg0", 32'(rs1_val), 32'hAB);

      // reset with a write pending and another presented: both dropped
      drive(1'b1, 1'b0, 1'b0, 2'd3, 8'h99, 8'h00);
      step();
      reset = 1'b1;
      step();
      rd_both(2'd3);
      chk("rstmid_fwd_valid", 32'(fwd_valid), 32'h0);
      chk("rstmid_count", 32'(wb_count), 32'h0);
      reset = 1'b0;
      idle();
      step();
      chk("rstmid_reg3", 32'(rs1_val), 32'h00);
      chk("rstmid_count_after", 32'(wb_count), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 8-bit pipelined processor; sits directly downstream of the memory stage.
- Registers the memory-stage results (ALU/accumulator value, memory read data, destination register, control bits) into a MEM/WB pipeline register.
- Selects the write-back value and commits it to the architectural register file; exposes two read ports with write-through bypass, plus forwarding signals for the execute stage.

Parameters:
- DATA_W, 8, datapath width
- ADDR_W, 2, register index width
- REG_COUNT, 4, number of architectural registers (2**ADDR_W)
- RESET_VAL, 8'h00, reset value of every register and pipeline field

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Wr_MEM  input  1  register-write enable from memory stage
- Rm_MEM  input  1  memory-read flag; 1 = write back data_out, 0 = write back acOutWb
- rdmem  input  ADDR_W  destination register index
- acOutWb  input  DATA_W  ALU/accumulator result
- data_out  input  DATA_W  memory read data
- flush  input  1  squash the instruction entering the pipeline register this cycle
- rs1  input  ADDR_W  read port 1 index
- rs2  input  ADDR_W  read port 2 index
- rs1_val  output  DATA_W  read port 1 data (combinational)
- rs2_val  output  DATA_W  read port 2 data (combinational)
- fwd_valid  output  1  pipeline register holds a valid register write
- fwd_rd  output  ADDR_W  destination of that write
- fwd_val  output  DATA_W  value of that write
- wb_count  output  8  count of committed register writes, wraps

Behaviour:
- Clock and reset: one clock, `clock`; reset is `reset`, synchronous and active-high. Sampled only on the rising edge of `clock`.
- Reset values:
  - pipeline register fields (wr, rd, val) cleared to 0 / RESET_VAL
  - all REG_COUNT registers set to RESET_VAL
  - wb_count = 0
  - fwd_valid = 0, fwd_rd = 0, fwd_val = RESET_VAL
- Reset wins over every other input in the same cycle.
- Stage 1, capture (rising edge):
  - wb_wr <= Wr_MEM & ~flush
  - wb_rd <= rdmem
  - wb_val <= Rm_MEM ? data_out : acOutWb
  - Mux is resolved before capture, so a single value is stored.
- Stage 2, commit (same rising edge, using previous-cycle contents):
  - if wb_wr, then regs[wb_rd] <= wb_val and wb_count <= wb_count + 1
  - wb_count wraps 8'hFF -> 8'h00
- Latency: inputs presented at edge N are captured at N and committed at N+1. The value is visible on read ports from edge N (via bypass) and architecturally from N+1.
- Read ports, combinational:
  - rsX_val = (wb_wr && wb_rd == rsX) ? wb_val : regs[rsX]
  - Bypass covers the write pending in the pipeline register.
  - Both ports may read the same index, including the bypassed one.
- Forwarding outputs (direct register outputs, no logic after the flops): fwd_valid = wb_wr, fwd_rd = wb_rd, fwd_val = wb_val.
- Boundary conditions:
  - flush=1 with Wr_MEM=1: nothing committed, wb_count unchanged; rd/val still captured but marked invalid.
  - Back-to-back writes to the same rd: later write wins; both count.
  - Wr_MEM=0: register file unchanged, including when Rm_MEM=1.
  - reset asserted mid-stream: the pending write in the pipeline register is dropped, not committed.
  - No stall input: a new instruction is accepted every cycle.

Decomposition:
- Shared package `cpu_pkg`:
  - DATA_W, ADDR_W, REG_COUNT constants
  - reg_idx_t (ADDR_W bits), word_t (DATA_W bits)
  - write-back source select encoding: WB_SRC_ALU=0, WB_SRC_MEM=1
- Sub-module `regfile_4x8`: storage, one write port, two read ports with bypass.
- wb_stage holds the pipeline register, source mux, counter and forwarding outputs.

Test Plan:
- Reset, then read all rs1/rs2 indices -> every read returns 8'h00; wb_count=0; fwd_valid=0.
- Wr_MEM=1, Rm_MEM=0, rdmem=2, acOutWb=8'h5A for 1 cycle -> fwd_valid=1, fwd_rd=2, fwd_val=8'h5A and rs1=2 reads 8'h5A (bypass) after edge N; after N+1, regs[2]=8'h5A, wb_count=1.
- Wr_MEM=1, Rm_MEM=1, rdmem=1, data_out=8'hC3, acOutWb=8'h11 -> regs[1]=8'hC3 (memory source selected).
- Consecutive writes r3=8'h01 then r3=8'h02; rs1=rs2=3 -> reads 8'h01 then 8'h02 on successive cycles; final regs[3]=8'h02; wb_count +2.
- flush=1 with Wr_MEM=1, rdmem=0, acOutWb=8'hFF -> fwd_valid=0, regs[0] unchanged, wb_count unchanged.
- Preload wb_count=8'hFF via 255 writes, then one more write -> wb_count=8'h00. Separately, assert reset while a write is pending -> target register stays 8'h00.
